rx_serial_7e1_uc: RTL and testbench

//  Control unit for the 7E1 async serial receiver datapath. Detects the start bit
//  and times each bit to its centre with an internal baud counter. Drives the

---
 rtl/serial_rx_pkg.sv | 27 ++
 rtl/baud_tick_gen.sv | 41 ++++
 rtl/rx_serial_7e1_uc.sv | 139 +++++++++++++
 tb/tb_rx_serial_7e1_uc.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared definitions for the 7E1 serial receiver: FSM state codes and the
// default bit period.
package serial_rx_pkg;

    localparam int CLKS_PER_BIT_DEF = 5208;

    localparam logic [3:0] ST_INICIAL      = 4'd0;
    localparam logic [3:0] ST_PREPARA      = 4'd1;
    localparam logic [3:0] ST_ESPERA_START = 4'd2;
    localparam logic [3:0] ST_VALIDA       = 4'd3;
    localparam logic [3:0] ST_ESPERA_BIT   = 4'd4;
    localparam logic [3:0] ST_VERIFICA     = 4'd5;
    localparam logic [3:0] ST_REGISTRA     = 4'd6;
    localparam logic [3:0] ST_PRONTO       = 4'd7;

    typedef enum logic [3:0] {
        INICIAL      = ST_INICIAL,
        PREPARA      = ST_PREPARA,
        ESPERA_START = ST_ESPERA_START,
        VALIDA       = ST_VALIDA,
        ESPERA_BIT   = ST_ESPERA_BIT,
        VERIFICA     = ST_VERIFICA,
        REGISTRA     = ST_REGISTRA,
        PRONTO       = ST_PRONTO
    } state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Baud counter: counts clock cycles and pulses tick on the half- or full-bit
// target; wraps to zero on tick or on a synchronous clear.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic half,
    output logic tick
);

    localparam logic [CNT_W-1:0] HALF_TGT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TGT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] target_s;

    // Select the active target and flag when the counter reaches it
    always_comb begin
        if (half) begin
            target_s = HALF_TGT;
        end else begin
            target_s = FULL_TGT;
        end
        tick = (cnt_r == target_s);
    end

    // Counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear || tick) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/rx_serial_7e1_uc.sv
// Control unit of the 7E1 asynchronous serial receiver: start detection,
// bit-centre timing, datapath strobes, parity/stop checking and ready pulse.
module rx_serial_7e1_uc
    import serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int CNT_W        = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       RX,
    input  logic       fim,
    input  logic       par_ok,
    output logic       zera,
    output logic       carrega,
    output logic       desloca,
    output logic       conta,
    output logic       registra,
    output logic       erro,
    output logic       pronto,
    output logic       erro_paridade,
    output logic       erro_stop,
    output logic [3:0] db_estado
);

    state_t state_r;
    state_t next_s;
    logic   tick_s;
    logic   clear_s;
    logic   half_s;
    logic   shift_s;
    logic   stop_ok_r;

    // Any state change restarts the bit timer; VALIDA times only half a bit
    assign clear_s = (next_s != state_r);
    assign half_s  = (state_r == VALIDA);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clock (clock),
        .reset (reset),
        .clear (clear_s),
        .half  (half_s),
        .tick  (tick_s)
    );

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            INICIAL:      next_s = PREPARA;
            PREPARA:      next_s = ESPERA_START;
            ESPERA_START: begin
                if (!RX) begin
                    next_s = VALIDA;
                end else begin
                    next_s = ESPERA_START;
                end
            end
            VALIDA: begin
                if (tick_s) begin
                    if (RX) begin
                        next_s = ESPERA_START;
                    end else begin
                        next_s = ESPERA_BIT;
                    end
                end else begin
                    next_s = VALIDA;
                end
            end
            ESPERA_BIT: begin
                if (tick_s && fim) begin
                    next_s = VERIFICA;
                end else begin
                    next_s = ESPERA_BIT;
                end
            end
            VERIFICA:     next_s = REGISTRA;
            REGISTRA:     next_s = PRONTO;
            PRONTO:       next_s = PREPARA;
            default:      next_s = INICIAL;
        endcase
    end

    // State register and stop-bit capture on the final sample tick
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= INICIAL;
            stop_ok_r <= 1'b0;
        end else begin
            state_r <= next_s;
            if (state_r == ESPERA_BIT && tick_s && fim) begin
                stop_ok_r <= RX;
            end else begin
                stop_ok_r <= stop_ok_r;
            end
        end
    end

    // Shift and count fire in the tick cycle itself, so they stay combinational
    assign shift_s = tick_s && (((state_r == VALIDA) && !RX) || (state_r == ESPERA_BIT));
    assign desloca = shift_s;
    assign conta   = shift_s;

    // Moore outputs registered from the next state so they align with state_r
    always_ff @(posedge clock) begin
        if (reset) begin
            zera          <= 1'b1;
            carrega       <= 1'b1;
            registra      <= 1'b0;
            erro          <= 1'b0;
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_stop     <= 1'b0;
        end else begin
            zera     <= (next_s == INICIAL) || (next_s == PREPARA);
            carrega  <= (next_s == INICIAL) || (next_s == PREPARA);
            registra <= (next_s == REGISTRA);
            pronto   <= (next_s == PRONTO);
            // erro only in REGISTRA: it would otherwise corrupt par_ok in VERIFICA
            erro     <= (next_s == REGISTRA) && (!par_ok || !stop_ok_r);
            if (state_r == PREPARA) begin
                erro_paridade <= 1'b0;
                erro_stop     <= 1'b0;
            end else if (state_r == VERIFICA) begin
                erro_paridade <= !par_ok;
                erro_stop     <= !stop_ok_r;
            end else begin
                erro_paridade <= erro_paridade;
                erro_stop     <= erro_stop;
            end
        end
    end

    assign db_estado = state_r;

endmodule

// File: tb/tb_rx_serial_7e1_uc.sv
// Bench for rx_serial_7e1_uc with a behavioural receiver datapath attached;
// received characters are checked against a scoreboard queue.
module tb_rx_serial_7e1_uc;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       RX;
    logic       fim;
    logic       par_ok;
    logic       zera, carrega, desloca, conta, registra, erro, pronto;
    logic       erro_paridade, erro_stop;
    logic [3:0] db_estado;

    logic [9:0] sr = 10'h3FF;
    logic [3:0] q = 4'd0;
    logic [6:0] dados_ascii = 7'h00;

    int n_pass = 0;
    int n_total = 0;
    int desloca_cnt = 0;
    int pronto_cnt = 0;
    int erro_bad = 0;
    int pronto_double = 0;
    logic pronto_prev = 1'b0;

    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];

    always #5 clock = ~clock;

    rx_serial_7e1_uc #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .RX            (RX),
        .fim           (fim),
        .par_ok        (par_ok),
        .zera          (zera),
        .carrega       (carrega),
        .desloca       (desloca),
        .conta         (conta),
        .registra      (registra),
        .erro          (erro),
        .pronto        (pronto),
        .erro_paridade (erro_paridade),
        .erro_stop     (erro_stop),
        .db_estado     (db_estado)
    );

    // Receiver datapath: bit counter, 10-bit shift register, output register
    always_ff @(posedge clock) begin
        if (zera) q <= 4'd0;
        else if (conta) q <= q + 4'd1;
        if (carrega) sr <= 10'h3FF;
        else if (desloca) sr <= {RX, sr[9:1]};
        if (registra) dados_ascii <= erro ? 7'h3F : sr[7:1];
    end
    assign fim    = (q == 4'd9);
    assign par_ok = ~(^sr[8:1]);

    // Monitor: collect characters and watch pulse-shape invariants
    always @(negedge clock) begin
        if (desloca) desloca_cnt++;
        if (pronto) begin
            pronto_cnt++;
            obs_q.push_back({dados_ascii, erro_paridade, erro_stop});
        end
        if (erro && !registra) erro_bad++;
        if (pronto && pronto_prev) pronto_double++;
        pronto_prev = pronto;
    end

    task automatic send_bit(input logic v);
        @(negedge clock) RX = v;
        repeat (CPB - 1) @(negedge clock);
    endtask

    task automatic send_frame(input logic [6:0] d, input logic flip, input logic stop);
        logic p;
        p = (^d) ^ flip;
        exp_q.push_back({((flip || !stop) ? 7'h3F : d), flip, !stop});
        send_bit(1'b0);
        for (int i = 0; i < 7; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stop);
        @(negedge clock) RX = 1'b1;
    endtask

    task automatic wait_results();
        int t;
        t = 0;
        while (obs_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clock);
            t++;
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        RX = 1'b1;
        repeat (3) @(negedge clock);
        n_total++; if (db_estado !== 4'd0) $display("FAIL reset_state: got %0d want 0", db_estado); else n_pass++;
        n_total++; if ({zera, carrega} !== 2'b11) $display("FAIL reset_zera_carrega: got %b want 11", {zera, carrega}); else n_pass++;
        n_total++; if ({registra, erro, pronto} !== 3'b000) $display("FAIL reset_strobes: got %b want 000", {registra, erro, pronto}); else n_pass++;
        n_total++; if ({erro_paridade, erro_stop} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {erro_paridade, erro_stop}); else n_pass++;
        n_total++; if ({desloca, conta} !== 2'b00) $display("FAIL reset_shift: got %b want 00", {desloca, conta}); else n_pass++;
        reset = 1'b0;
        @(negedge clock);
        n_total++; if (db_estado !== 4'd1) $display("FAIL reset_to_prepara: got %0d want 1", db_estado); else n_pass++;
        @(negedge clock);
        n_total++; if (db_estado !== 4'd2) $display("FAIL prepara_to_wait: got %0d want 2", db_estado); else n_pass++;
        n_total++; if ({zera, carrega} !== 2'b00) $display("FAIL idle_zera_carrega: got %b want 00", {zera, carrega}); else n_pass++;
    endtask

    task automatic test_frames();
        logic [8:0] o, e;
        int p0;
        p0 = pronto_cnt;
        send_frame(7'h41, 1'b0, 1'b1);
        wait_results();
        send_frame(7'h41, 1'b1, 1'b1);
        wait_results();
        send_frame(7'h41, 1'b0, 1'b0);
        wait_results();
        repeat (60) @(negedge clock);
        n_total++; if (pronto_cnt - p0 !== 3) $display("FAIL frames_pronto_count: got %0d want 3", pronto_cnt - p0); else n_pass++;
        n_total++; if (obs_q.size() !== exp_q.size()) $display("FAIL frames_result_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL frame_result: got data=%h ep=%b es=%b want data=%h ep=%b es=%b", o[8:2], o[1], o[0], e[8:2], e[1], e[0]);
            else n_pass++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_glitch();
        int d0, p0;
        d0 = desloca_cnt;
        p0 = pronto_cnt;
        @(negedge clock) RX = 1'b0;
        repeat (3) @(negedge clock);
        @(negedge clock) RX = 1'b1;
        repeat (40) @(negedge clock);
        n_total++; if (desloca_cnt !== d0) $display("FAIL glitch_desloca: got %0d want %0d", desloca_cnt, d0); else n_pass++;
        n_total++; if (pronto_cnt !== p0) $display("FAIL glitch_pronto: got %0d want %0d", pronto_cnt, p0); else n_pass++;
        n_total++; if (db_estado !== 4'd2) $display("FAIL glitch_state: got %0d want 2", db_estado); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] o, e;
        int p0;
        p0 = pronto_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        @(negedge clock) reset = 1'b1;
        @(negedge clock);
        n_total++; if (db_estado !== 4'd0) $display("FAIL midreset_state: got %0d want 0", db_estado); else n_pass++;
        reset = 1'b0;
        RX = 1'b1;
        repeat (40) @(negedge clock);
        n_total++; if (pronto_cnt !== p0) $display("FAIL midreset_no_pronto: got %0d want %0d", pronto_cnt, p0); else n_pass++;
        send_frame(7'h55, 1'b0, 1'b1);
        wait_results();
        n_total++; if (pronto_cnt - p0 !== 1) $display("FAIL midreset_pronto_count: got %0d want 1", pronto_cnt - p0); else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL midreset_result: got data=%h ep=%b es=%b want data=%h ep=%b es=%b", o[8:2], o[1], o[0], e[8:2], e[1], e[0]);
            else n_pass++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [8:0] o, e;
        int p0;
        p0 = pronto_cnt;
        send_frame(7'h30, 1'b0, 1'b1);
        send_frame(7'h7A, 1'b0, 1'b1);
        wait_results();
        n_total++; if (pronto_cnt - p0 !== 2) $display("FAIL b2b_pronto_count: got %0d want 2", pronto_cnt - p0); else n_pass++;
        n_total++; if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_result_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_total++;
            if (o !== e) $display("FAIL b2b_result: got data=%h ep=%b es=%b want data=%h ep=%b es=%b", o[8:2], o[1], o[0], e[8:2], e[1], e[0]);
            else n_pass++;
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_invariants();
        n_total++; if (erro_bad !== 0) $display("FAIL erro_outside_registra: got %0d want 0", erro_bad); else n_pass++;
        n_total++; if (pronto_double !== 0) $display("FAIL pronto_width: got %0d long pulses want 0", pronto_double); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_frames();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
